// File: rtl/link_credit_gate.sv
// link_credit_gate: credit-gated single-slot register stage between an ARQ sender and a link PHY.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_prio          : word offered by the ARQ (prio words bypass credits)
//   tx_accept/tx_reject               : word taken / word refused this cycle
//   link_valid/link_data/link_ready   : registered output word and PHY consume strobe
//   credit_valid/credit_init/credit_in: credit return (increment) or absolute load
//   credits, link_up, stalled, credit_overflow : status
module link_credit_gate #(
  parameter int LINK_WORD_SIZE = 40,
  parameter int CREDIT_WIDTH   = 8,
  parameter int MAX_CREDIT     = 16,
  parameter int STALL_TIMEOUT  = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_valid,
  input  logic [LINK_WORD_SIZE-1:0] tx_data,
  input  logic                      tx_prio,
  output logic                      tx_accept,
  output logic                      tx_reject,
  output logic                      link_valid,
  output logic [LINK_WORD_SIZE-1:0] link_data,
  input  logic                      link_ready,
  input  logic                      credit_valid,
  input  logic                      credit_init,
  input  logic [CREDIT_WIDTH-1:0]   credit_in,
  output logic [CREDIT_WIDTH-1:0]   credits,
  output logic                      link_up,
  output logic                      stalled,
  output logic                      credit_overflow
);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CREDIT_WIDTH:0]   MAX_W = (CREDIT_WIDTH + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDIT);
  typedef enum logic [1:0] {INIT, UP, STALL} state_t;
  state_t                    state_q, state_d;
  logic [CREDIT_WIDTH-1:0]   credits_q, credits_d;
  logic                      link_valid_q, link_valid_d;
  logic [LINK_WORD_SIZE-1:0] link_data_q, link_data_d;
  logic [SW-1:0]             stall_cnt_q, stall_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      slot_free, offer, dec, load, sat;
  logic [CREDIT_WIDTH:0]     sum, raw;
  always_comb begin
    slot_free    = ~link_valid_q | link_ready;
    offer        = tx_valid & slot_free & (state_q != INIT);
    tx_accept    = offer & (tx_prio | (credits_q != '0));
    tx_reject    = offer & ~tx_prio & (credits_q == '0);
    dec          = tx_accept & ~tx_prio;
    load         = credit_valid & credit_init;
    // One extra bit so the add can exceed MAX_CREDIT before clamping; the
    // decrement only fires with credits_q != 0, so no underflow.
    sum          = {1'b0, credits_q} + (credit_valid ? {1'b0, credit_in} : '0) - {{CREDIT_WIDTH{1'b0}}, dec};
    raw          = load ? {1'b0, credit_in} : sum;
    sat          = raw > MAX_W;
    credits_d    = sat ? MAX_C : raw[CREDIT_WIDTH-1:0];
    overflow_d   = overflow_q | sat;
    stall_cnt_d  = (state_q == UP && credits_q == '0 && !credit_valid) ? stall_cnt_q + SW'(1) : '0;
    // Stall is declared on the cycle the counter reaches the timeout.
    state_d      = load ? UP
                 : (state_q == UP && stall_cnt_d == SW'(STALL_TIMEOUT)) ? STALL
                 : (state_q == STALL && credit_valid && credits_d != '0) ? UP
                 : state_q;
    link_valid_d = tx_accept | (link_valid_q & ~link_ready);
    link_data_d  = tx_accept ? tx_data : link_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      credits_q    <= '0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      stall_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      stall_cnt_q  <= stall_cnt_d;
      overflow_q   <= overflow_d;
    end
  end
  assign link_valid      = link_valid_q;
  assign link_data       = link_data_q;
  assign credits         = credits_q;
  assign link_up         = state_q != INIT;
  assign stalled         = state_q == STALL;
  assign credit_overflow = overflow_q;
endmodule
